// File: rtl/insn_decode_queue.sv
// insn_decode_queue: DEPTH-entry FIFO of pre-decoded vector instructions.
// Ports: clk, rst (async active-low), in_valid/in_ready/insn_in (enqueue),
//   out_valid/out_ready (dequeue), head field outputs, insn_class, count,
//   illegal (one-cycle drop pulse).
// Macro INSN_DECODE_ILLEGAL_DROP_EN drops illegal instructions at enqueue.
module insn_decode_queue #(
    parameter int INSN_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [INSN_WIDTH-1:0]   insn_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [6:0]              opcode_mjr,
    output logic [2:0]              opcode_mnr,
    output logic [4:0]              dest,
    output logic [4:0]              src_1,
    output logic [4:0]              src_2,
    output logic [2:0]              width,
    output logic [1:0]              mop,
    output logic                    mew,
    output logic [2:0]              nf,
    output logic [10:0]             vtype_11,
    output logic [9:0]              vtype_10,
    output logic [1:0]              cfg_type,
    output logic                    vm,
    output logic [5:0]              funct6,
    output logic [1:0]              insn_class,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    illegal
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [1:0]  cls;
        logic [31:0] bits;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rdy_en;

    logic [31:0] raw;
    logic [6:0]  op_in;
    logic [2:0]  mnr_in;
    logic        is_v;
    logic        is_ld;
    logic        is_st;
    logic [1:0]  cls_in;
    logic        bad;
    logic        push;
    logic        pop;
    logic        store;

    assign raw    = insn_in[31:0];
    assign op_in  = raw[6:0];
    assign mnr_in = raw[14:12];
    assign is_v   = (op_in == 7'h57);
    assign is_ld  = (op_in == 7'h07);
    assign is_st  = (op_in == 7'h27);

    always_comb begin
        cls_in = 2'd0;
        unique case (1'b1)
            is_v:    cls_in = (mnr_in == 3'd7) ? 2'd3 : 2'd0;
            is_ld:   cls_in = 2'd1;
            is_st:   cls_in = 2'd2;
            default: cls_in = 2'd0;
        endcase
    end

`ifdef INSN_DECODE_ILLEGAL_DROP_EN
    // Loads/stores only allow element widths 8/16/32/64 (0,5,6,7).
    assign bad = !(is_v || is_ld || is_st) ||
                 ((is_ld || is_st) &&
                  !(mnr_in == 3'd0 || mnr_in >= 3'd5));
`else
    assign bad = 1'b0;
`endif

    // rdy_en holds in_ready low through reset and the release edge.
    assign in_ready  = rdy_en && (count < FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign store     = push && !bad;

    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= '{cls: cls_in, bits: raw};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (store) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({store, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef INSN_DECODE_ILLEGAL_DROP_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) illegal <= 1'b0;
        else      illegal <= push && bad;
    end
`else
    assign illegal = 1'b0;
`endif

    entry_t      head;
    logic [31:0] h;

    assign head       = mem[rd_ptr];
    assign h          = out_valid ? head.bits : 32'd0;
    assign insn_class = out_valid ? head.cls : 2'd0;

    assign opcode_mjr = h[6:0];
    assign opcode_mnr = h[14:12];
    assign dest       = h[11:7];
    assign src_1      = h[19:15];
    assign src_2      = h[24:20];
    assign width      = h[14:12];
    assign mop        = h[27:26];
    assign mew        = h[28];
    assign nf         = h[31:29];
    assign vtype_11   = h[30:20];
    assign vtype_10   = h[29:20];
    assign cfg_type   = h[31:30];
    assign vm         = h[25];
    assign funct6     = h[31:26];

endmodule

// File: tb/tb_insn_decode_queue.sv
// tb_insn_decode_queue: directed scoreboard bench for insn_decode_queue.
// Drives handshakes cycle by cycle and checks against a queue model.
module tb_insn_decode_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     insn_in;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      opcode_mjr;
    logic [2:0]      opcode_mnr;
    logic [4:0]      dest;
    logic [4:0]      src_1;
    logic [4:0]      src_2;
    logic [2:0]      width;
    logic [1:0]      mop;
    logic            mew;
    logic [2:0]      nf;
    logic [10:0]     vtype_11;
    logic [9:0]      vtype_10;
    logic [1:0]      cfg_type;
    logic            vm;
    logic [5:0]      funct6;
    logic [1:0]      insn_class;
    logic [CW-1:0]   count;
    logic            illegal;

    int total = 0;
    int bad   = 0;

    logic [31:0] q[$];
    logic        rdy_en;

    always #5 clk = ~clk;

    insn_decode_queue #(.INSN_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .insn_in(insn_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode_mjr(opcode_mjr), .opcode_mnr(opcode_mnr), .dest(dest),
        .src_1(src_1), .src_2(src_2), .width(width), .mop(mop),
        .mew(mew), .nf(nf), .vtype_11(vtype_11), .vtype_10(vtype_10),
        .cfg_type(cfg_type), .vm(vm), .funct6(funct6),
        .insn_class(insn_class), .count(count), .illegal(illegal)
    );

    function automatic logic [63:0] exp_fields(input logic [31:0] i);
        return {i[6:0], i[14:12], i[11:7], i[19:15], i[24:20],
                i[14:12], i[27:26], i[28], i[31:29], i[30:20],
                i[29:20], i[31:30], i[25], i[31:26]};
    endfunction

    function automatic logic [1:0] exp_class(input logic [31:0] i);
        if (i[6:0] == 7'h57) return (i[14:12] == 3'd7) ? 2'd3 : 2'd0;
        if (i[6:0] == 7'h07) return 2'd1;
        if (i[6:0] == 7'h27) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic exp_legal(input logic [31:0] i);
`ifdef INSN_DECODE_ILLEGAL_DROP_EN
        logic [6:0] op;
        logic [2:0] w;
        op = i[6:0];
        w  = i[14:12];
        if (op == 7'h57) return 1'b1;
        if (op == 7'h07 || op == 7'h27)
            return (w == 3'd0 || w == 3'd5 || w == 3'd6 || w == 3'd7);
        return 1'b0;
`else
        return (i == i);
`endif
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] dut_fields();
        return {opcode_mjr, opcode_mnr, dest, src_1, src_2, width, mop,
                mew, nf, vtype_11, vtype_10, cfg_type, vm, funct6};
    endfunction

    // One clock: drive, check pre-edge outputs, clock, update model.
    task automatic cycle(input logic iv, input logic [31:0] d,
                         input logic ordy);
        logic ex_rdy;
        logic ex_push;
        logic ex_pop;
        logic ex_ill;
        in_valid  = iv;
        insn_in   = d;
        out_ready = ordy;
        #1;
        ex_rdy = rdy_en && (q.size() < DEPTH);
        chk("in_ready", 64'(in_ready), 64'(ex_rdy));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("count", 64'(count), 64'(q.size()));
        if (q.size() != 0) begin
            chk("head_fields", dut_fields(), exp_fields(q[0]));
            chk("head_class", 64'(insn_class), 64'(exp_class(q[0])));
        end else begin
            chk("idle_fields", dut_fields(), 64'd0);
            chk("idle_class", 64'(insn_class), 64'd0);
        end
        ex_push = iv && ex_rdy;
        ex_pop  = ordy && (q.size() != 0);
        ex_ill  = ex_push && !exp_legal(d);
        @(posedge clk);
        #1;
        if (ex_pop) void'(q.pop_front());
        if (ex_push && !ex_ill) q.push_back(d);
        rdy_en = 1'b1;
        chk("illegal", 64'(illegal), 64'(ex_ill));
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        insn_in   = 32'd0;
        out_ready = 1'b0;
        rdy_en    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk("rst_fields", dut_fields(), 64'd0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        rdy_en = 1'b1;

        // vsetvli-style config insn, then fill to DEPTH
        cycle(1'b1, 32'h0200F057, 1'b0);
        chk("cfg_class", 64'(insn_class), 64'd3);
        chk("cfg_mnr", 64'(opcode_mnr), 64'd7);
        chk("cfg_count", 64'(count), 64'd1);
        cycle(1'b1, 32'h02005087, 1'b0);
        cycle(1'b1, 32'h1A0061A7, 1'b0);
        cycle(1'b1, 32'hB6A19257, 1'b0);
        chk("full_count", 64'(count), 64'(DEPTH));
        // push while full is ignored; head held stable
        cycle(1'b1, 32'hFFFFF057, 1'b0);
        cycle(1'b1, 32'h00007007, 1'b0);

        // drain in order, plus one pop while empty
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 32'd0, 1'b1);

        // streaming at count==1
        cycle(1'b1, 32'h12345057, 1'b0);
        for (int i = 0; i < 2 * DEPTH; i++)
            cycle(1'b1, {8'(i), 24'h00F057} ^ 32'h00A00000, 1'b1);
        chk("stream_count", 64'(count), 64'd1);

        // fill to DEPTH-1, push+pop there, then pop-only at full
        for (int i = 0; i < DEPTH - 2; i++)
            cycle(1'b1, 32'h04106007 + 32'(i << 7), 1'b0);
        cycle(1'b1, 32'h08305027, 1'b1);
        chk("dm1_count", 64'(count), 64'(DEPTH - 1));
        cycle(1'b1, 32'h0C107057, 1'b0);
        cycle(1'b1, 32'h0C207057, 1'b1);
        chk("full_pop_count", 64'(count), 64'(DEPTH - 1));
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'd0, 1'b1);

        // non-vector opcode and bad load width
        cycle(1'b1, 32'h00000013, 1'b0);
        cycle(1'b1, 32'h00001007, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'd0, 1'b1);

        // asynchronous reset at count==3
        cycle(1'b1, 32'h00105057, 1'b0);
        cycle(1'b1, 32'h00206007, 1'b0);
        cycle(1'b1, 32'h00307027, 1'b0);
        chk("pre_rst_count", 64'(count), 64'd3);
        #2 rst = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        q.delete();
        rdy_en = 1'b0;
        #1 rst = 1'b1;
        cycle(1'b1, 32'h0AAAA057, 1'b0);
        cycle(1'b1, 32'h0200F057, 1'b0);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_class", 64'(insn_class), 64'd3);
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
